window_output_padder_17x17: RTL and testbench

Rebuilds a full-size raster frame from the valid-gated output stream of the 17x17 window stage. Feeds a border value into the 8-pixel margin that a 17x17 window cannot produce, and passes the interior results through in raster order. Sits between the 17x17 filter datapath and the frame writer. It is the consumer end of the window stage's `done_o` / `progress_done` stream.

---
 rtl/window_output_padder_17x17_pkg.sv | 17 +
 rtl/window_output_padder_17x17_fifo.sv | 55 +++++
 rtl/window_output_padder_17x17.sv | 135 +++++++++++++
 tb/tb_window_output_padder_17x17.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_output_padder_17x17_pkg.sv
// Shared definitions for the 17x17 output padder: FSM state encoding and the
// border width implied by a 17x17 window.
package window_output_padder_17x17_pkg;

  localparam int PAD_17X17 = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TOP    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_MID    = 3'd3,
    ST_RIGHT  = 3'd4,
    ST_BOTTOM = 3'd5,
    ST_DONE   = 3'd6
  } pad_state_t;

endpackage

// File: rtl/window_output_padder_17x17_fifo.sv
// First-word-fall-through skid FIFO holding interior pixels until the raster
// scan reaches the interior region. Flush empties it in one cycle.
module padder_sync_fifo
  import window_output_padder_17x17_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push_ok, pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/window_output_padder_17x17.sv
// Rebuilds a full raster frame from the 17x17 window stage's interior stream,
// filling the PAD-wide margin with BORDER_VAL. Define PADDER_OVF_DETECT_EN for overflow_o.
module window_output_padder_17x17
  import window_output_padder_17x17_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int PAD        = PAD_17X17,
  parameter int BORDER_VAL = 0,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(ROWS)-1:0]  row_o,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic                     busy_o,
  output logic                     frame_done_o
`ifdef PADDER_OVF_DETECT_EN
  , output logic                   overflow_o
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0]     ROW_TOP_END = RW'(PAD - 1);
  localparam logic [RW-1:0]     ROW_MID_END = RW'(ROWS - 1 - PAD);
  localparam logic [RW-1:0]     ROW_END     = RW'(ROWS - 1);
  localparam logic [CW-1:0]     COL_LFT_END = CW'(PAD - 1);
  localparam logic [CW-1:0]     COL_MID_END = CW'(COLS - 1 - PAD);
  localparam logic [CW-1:0]     COL_END     = CW'(COLS - 1);
  localparam logic [DATA_W-1:0] BORDER      = DATA_W'(BORDER_VAL);

  pad_state_t        state, state_nxt;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              xfer, start_ok, push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign xfer     = valid_o & ready_i;
  assign start_ok = start_i & (state == ST_IDLE);
  assign push     = valid_i & (busy_o | start_ok);
  assign flush    = (state == ST_DONE);
  assign row_o    = row_q;
  assign col_o    = col_q;

  padder_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Raster position advances only on an accepted output pixel.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      row_q <= '0;
      col_q <= '0;
    end else if (xfer) begin
      if (col_q == COL_END) begin
        col_q <= '0;
        row_q <= (row_q == ROW_END) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_TOP;
      ST_TOP:    if (xfer && row_q == ROW_TOP_END && col_q == COL_END) state_nxt = ST_LEFT;
      ST_LEFT:   if (xfer && col_q == COL_LFT_END) state_nxt = ST_MID;
      ST_MID:    if (xfer && col_q == COL_MID_END) state_nxt = ST_RIGHT;
      ST_RIGHT:  if (xfer && col_q == COL_END)
                   state_nxt = (row_q < ROW_MID_END) ? ST_LEFT : ST_BOTTOM;
      ST_BOTTOM: if (xfer && row_q == ROW_END && col_q == COL_END) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_o      = 1'b0;
    data_o       = '0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    pop          = 1'b0;
    case (state)
      ST_IDLE: busy_o = 1'b0;
      ST_TOP, ST_LEFT, ST_RIGHT, ST_BOTTOM: begin
        valid_o = 1'b1;
        data_o  = BORDER;
      end
      ST_MID: begin
        valid_o = ~fifo_empty;
        data_o  = fifo_empty ? '0 : fifo_head;
        pop     = ready_i & ~fifo_empty;
      end
      ST_DONE: frame_done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

`ifdef PADDER_OVF_DETECT_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                   ovf_q <= 1'b0;
    else if (push && fifo_full) ovf_q <= 1'b1;
  end
  assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_window_output_padder_17x17.sv
// Scoreboard bench for window_output_padder_17x17 on a 20x20 frame; a second
// instance with a 4-deep FIFO covers overflow handling.
module tb_window_output_padder_17x17;

  typedef struct { int r; int c; int d; } exp_t;
  typedef exp_t exp_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_i, valid_i, ready_i;
  logic [7:0] data_i, data_o;
  logic       valid_o, busy_o, frame_done_o;
  logic [4:0] row_o, col_o;
  logic       start_s, valid_s, ready_s;
  logic [7:0] data_s, data_o_s;
  logic       valid_o_s, busy_o_s, frame_done_o_s;
  logic [4:0] row_o_s, col_o_s;
`ifdef PADDER_OVF_DETECT_EN
  logic       overflow_o, overflow_o_s;
`endif

  window_output_padder_17x17 #(.DATA_W(8), .ROWS(20), .COLS(20), .PAD(8),
    .BORDER_VAL(0), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i), .data_i(data_i),
    .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o), .row_o(row_o),
    .col_o(col_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef PADDER_OVF_DETECT_EN
    , .overflow_o(overflow_o)
`endif
  );

  window_output_padder_17x17 #(.DATA_W(8), .ROWS(20), .COLS(20), .PAD(8),
    .BORDER_VAL(0), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .start_i(start_s), .valid_i(valid_s), .data_i(data_s),
    .ready_i(ready_s), .valid_o(valid_o_s), .data_o(data_o_s), .row_o(row_o_s),
    .col_o(col_o_s), .busy_o(busy_o_s), .frame_done_o(frame_done_o_s)
`ifdef PADDER_OVF_DETECT_EN
    , .overflow_o(overflow_o_s)
`endif
  );

  int n_tests = 0, n_fail = 0;
  exp_t q[$], qs[$];
  int xfers = 0, xfers_s = 0, done_cnt = 0, done_cnt_s = 0;
  int cyc = 0, last_cyc = -10, last_cyc_s = -10;
  int rdy_mode = 0;
  int main_vals[16], small_vals[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_q_t make_frame(input int vals[16]);
    exp_q_t fq;
    exp_t e;
    int k = 0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        e.r = r; e.c = c;
        if (r >= 8 && r <= 11 && c >= 8 && c <= 11) begin
          e.d = vals[k]; k++;
        end else e.d = 0;
        fq.push_back(e);
      end
    return fq;
  endfunction

  // Main-instance monitor: scoreboard pop, stall hold and done-pulse timing.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d;
  logic [4:0] hold_r, hold_c;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, hold_d);
        chk("hold_row", row_o, hold_r);
        chk("hold_col", col_o, hold_c);
        hold_pend = 1'b0;
      end
      if (valid_o && !ready_i) begin
        hold_pend = 1'b1; hold_d = data_o; hold_r = row_o; hold_c = col_o;
      end
      if (valid_o && ready_i) begin
        xfers++;
        if (q.size() == 0) chk("sb_extra_xfer", xfers, 0);
        else begin
          e = q.pop_front();
          chk("px_row", row_o, e.r);
          chk("px_col", col_o, e.c);
          chk("px_data", data_o, e.d);
        end
        if (row_o == 19 && col_o == 19) last_cyc = cyc;
      end
      if (frame_done_o) begin
        done_cnt++;
        chk("done_timing", cyc, last_cyc + 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid_o_s && ready_s) begin
        xfers_s++;
        if (qs.size() == 0) chk("sbs_extra_xfer", xfers_s, 0);
        else begin
          e = qs.pop_front();
          chk("pxs_row", row_o_s, e.r);
          chk("pxs_col", col_o_s, e.c);
          chk("pxs_data", data_o_s, e.d);
        end
        if (row_o_s == 19 && col_o_s == 19) last_cyc_s = cyc;
      end
      if (frame_done_o_s) begin
        done_cnt_s++;
        chk("dones_timing", cyc, last_cyc_s + 1);
      end
    end
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) ready_i = 1'b1;
      else               ready_i = ~ready_i;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_row"}, row_o, 0);
    chk({tag, "_col"}, col_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, frame_done_o, 0);
`ifdef PADDER_OVF_DETECT_EN
    chk({tag, "_ovf"}, overflow_o, 0);
`endif
  endtask

  task automatic run_frame(input int mode, input bit delayed, input bit repulse);
    int t, d0;
    q = make_frame(main_vals);
    xfers = 0; d0 = done_cnt; rdy_mode = mode;
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b0;
    if (delayed) begin
      t = 0;
      while (!(busy_o && row_o == 8 && col_o == 8) && t < 2000) begin tick(); t++; end
      chk("mid_reach", (t < 2000), 1);
      repeat (3) begin
        @(negedge clk);
        chk("mid_wait_valid", valid_o, 0);
        chk("mid_wait_row", row_o, 8);
        chk("mid_wait_col", col_o, 8);
      end
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      valid_i = 1'b1; data_i = 8'(main_vals[k]);
      start_i = (repulse && k == 3);
      tick();
    end
    valid_i = 1'b0; start_i = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin tick(); t++; end
    chk("frame_timeout", (t < 3000), 1);
    repeat (3) tick();
    chk("frame_xfers", xfers, 400);
    chk("frame_sb_empty", q.size(), 0);
    chk("frame_done_once", done_cnt, d0 + 1);
    chk("frame_idle_busy", busy_o, 0);
    rdy_mode = 0;
  endtask

  initial begin
    int t, d0;
    for (int k = 0; k < 16; k++) begin
      main_vals[k]  = k + 1;
      small_vals[k] = (k < 4) ? k + 1 : k + 3;
    end
    rst = 1'b1; start_i = 1'b0; valid_i = 1'b0; data_i = '0;
    start_s = 1'b0; valid_s = 1'b0; data_s = '0; ready_s = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("rst");
    chk("rst_s_valid", valid_o_s, 0);

    run_frame(0, 1'b0, 1'b1);   // full-rate frame, start re-pulsed mid-frame
    run_frame(1, 1'b0, 1'b0);   // ready toggling
    run_frame(0, 1'b1, 1'b0);   // interior arrives after TOP

    // Reset in the middle of row 9
    q = make_frame(main_vals); d0 = done_cnt;
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 16; k++) begin valid_i = 1'b1; data_i = 8'(k + 1); tick(); end
    valid_i = 1'b0;
    t = 0;
    while (row_o != 9 && t < 2000) begin tick(); t++; end
    chk("row9_reach", (t < 2000), 1);
    rst = 1'b1; q.delete();
    tick(); rst = 1'b0;
    check_reset_vals("midrst");
    repeat (5) tick();
    chk("midrst_no_done", done_cnt, d0);
    run_frame(0, 1'b0, 1'b0);

    // Small FIFO: 6 pushes while TOP is stalled
    qs = make_frame(small_vals); xfers_s = 0; d0 = done_cnt_s;
    tick(); start_s = 1'b1;
    tick(); start_s = 1'b0;
`ifdef PADDER_OVF_DETECT_EN
    chk("ovf_before", overflow_o_s, 0);
`endif
    for (int k = 0; k < 6; k++) begin valid_s = 1'b1; data_s = 8'(k + 1); tick(); end
    valid_s = 1'b0;
    chk("stall_row", row_o_s, 0);
    chk("stall_col", col_o_s, 0);
`ifdef PADDER_OVF_DETECT_EN
    chk("ovf_set", overflow_o_s, 1);
`endif
    ready_s = 1'b1;
    t = 0;
    while (!(row_o_s == 8 && col_o_s == 12) && t < 2000) begin tick(); t++; end
    chk("small_mid_reach", (t < 2000), 1);
    for (int k = 0; k < 12; k++) begin
      valid_s = 1'b1; data_s = 8'(k + 7); tick();
      valid_s = 1'b0;
      repeat (19) tick();
    end
    t = 0;
    while (done_cnt_s == d0 && t < 3000) begin tick(); t++; end
    chk("small_timeout", (t < 3000), 1);
    repeat (2) tick();
    chk("small_xfers", xfers_s, 400);
    chk("small_sb_empty", qs.size(), 0);
`ifdef PADDER_OVF_DETECT_EN
    chk("ovf_sticky", overflow_o_s, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
